// File: rtl/telemetry_pkg.sv
// Shared telemetry types: packet width, drop counter width and the issue FSM states.
package telemetry_pkg;

    localparam int PKT_W      = 88;
    localparam int DROP_CNT_W = 16;

    typedef logic [PKT_W-1:0] packet_t;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } issue_state_t;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/telemetry_pkt_ram.sv
// Packet storage: DEPTH x W array, one write port, one registered read port.
module telemetry_pkt_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 88,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register doubles as the serializer-facing packet; it holds between pops.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/telemetry_packet_fifo.sv
// Elastic packet buffer between the telemetry source and the serializer:
// paced source requests, DEPTH-slot FIFO, and a hold-off issue FSM with counted drops.
module telemetry_packet_fifo #(
    parameter int DEPTH       = 4,
    parameter int PKT_W       = 88,
    parameter int HOLDOFF     = 2,
    parameter int REQ_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset_clk,
    input  logic                       telemetry_trigger,
    output logic                       telemetry_request,
    input  logic [PKT_W-1:0]           packet,
    input  logic                       packet_valid,
    input  logic                       serializer_ready,
    output logic [PKT_W-1:0]           out_packet,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [15:0]                drop_count
);
    import telemetry_pkg::*;

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH+1);
    localparam int HOLD_W = (HOLDOFF > 2) ? $clog2(HOLDOFF-1) : 1;
    localparam int TMO_W  = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;

    issue_state_t            state_reg, state_next;
    logic [HOLD_W-1:0]       hold_cnt_reg;
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]        level_reg;
    logic [DROP_CNT_W-1:0]   drop_count_reg;
    logic                    outstanding_reg;
    logic [TMO_W-1:0]        tmo_cnt_reg;
    logic                    request_reg;
    logic                    out_valid_reg;

    logic full, pop, push, drop, issue_req, hold_done;

    assign full      = (level_reg == LVL_W'(DEPTH));
    // A full FIFO still takes a packet when the head leaves on the same edge.
    assign push      = packet_valid && (!full || pop);
    assign drop      = packet_valid && full && !pop;
    // Keep one slot free for the packet answering this request.
    assign issue_req = telemetry_trigger && !outstanding_reg && (level_reg < LVL_W'(DEPTH-1));
    assign hold_done = (hold_cnt_reg == HOLD_W'(HOLDOFF-2));

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= (state_reg == ST_HOLD) ? hold_cnt_reg + HOLD_W'(1) : '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (level_reg != '0 && serializer_ready) state_next = ST_HOLD;
            ST_HOLD: if (hold_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pop = (state_reg == ST_IDLE) && (level_reg != '0) && serializer_ready;
    end

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            out_valid_reg  <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            level_reg     <= level_reg + LVL_W'(push) - LVL_W'(pop);
            out_valid_reg <= pop;
            if (drop) drop_count_reg <= sat_inc(drop_count_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            request_reg     <= 1'b0;
            outstanding_reg <= 1'b0;
            tmo_cnt_reg     <= '0;
        end else begin
            request_reg <= issue_req;
            if (issue_req) begin
                outstanding_reg <= 1'b1;
                tmo_cnt_reg     <= '0;
            end else if (outstanding_reg) begin
                if (packet_valid || tmo_cnt_reg == TMO_W'(REQ_TIMEOUT-1)) begin
                    outstanding_reg <= 1'b0;
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                end
            end
        end
    end

    telemetry_pkt_ram #(
        .DEPTH (DEPTH),
        .W     (PKT_W)
    ) u_ram (
        .clk     (clk),
        .srst    (reset_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (packet),
        .rd_en   (pop),
        .rd_addr (rd_ptr_reg),
        .rd_data (out_packet)
    );

    assign telemetry_request = request_reg;
    assign out_valid         = out_valid_reg;
    assign level             = level_reg;
    assign drop_count        = drop_count_reg;

endmodule
